// File: rtl/demux1x4_buffered_pkg.sv
// demux1x4_buffered_pkg: shared channel constants and width helpers
package demux1x4_buffered_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W = 2;
   function automatic int cntWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction
   function automatic int sliceLsb(input int ch, input int width);
      return ch * width;
   endfunction
endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: single-channel synchronous FIFO with occupancy count
module demux_chan_fifo
   import demux1x4_buffered_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [cntWidth(DEPTH)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cntWidth(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wrPtr, rdPtr;
   logic push, pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign push = wr_en & ~full;
   assign pop = rd_en & ~empty;
   assign rd_data = mem[rdPtr];
   // storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wrPtr] <= wr_data;
            wrPtr <= wrPtr + PW'(1);
         end
         if (pop) rdPtr <= rdPtr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/demux1x4_buffered.sv
// demux1x4_buffered: routes a tagged word stream into four independently buffered channels
module demux1x4_buffered
   import demux1x4_buffered_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  in_data,
   input  logic [SEL_W-1:0]                  in_sel,
   output logic [NUM_CH-1:0]                 out_valid,
   input  logic [NUM_CH-1:0]                 out_ready,
   output logic [NUM_CH*WIDTH-1:0]           out_data,
   output logic [NUM_CH*cntWidth(DEPTH)-1:0] out_count
);
   localparam int CW = cntWidth(DEPTH);
   logic [NUM_CH-1:0] chFull, chEmpty;
   assign in_ready = ~chFull[in_sel];
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic wrEn;
      assign wrEn = in_valid & in_ready & (in_sel == SEL_W'(c));
      assign out_valid[c] = ~chEmpty[c];
      demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wrEn),
         .wr_data (in_data),
         .rd_en   (out_ready[c]),
         .rd_data (out_data[sliceLsb(c, WIDTH) +: WIDTH]),
         .full    (chFull[c]),
         .empty   (chEmpty[c]),
         .count   (out_count[sliceLsb(c, CW) +: CW])
      );
   end
endmodule

// File: tb/tb_demux1x4_buffered.sv
// tb_demux1x4_buffered: directed stimulus with per-channel scoreboard queues
module tb_demux1x4_buffered;
   logic clk = 0, rst = 1, inValid = 0, inReady;
   logic [3:0] inData = 0;
   logic [1:0] inSel = 0;
   logic [3:0] outValid, outReady = 0;
   logic [15:0] outData;
   logic [7:0] outCount;
   logic [3:0] q0[$], q1[$], q2[$], q3[$];
   int errors = 0, checks = 0;

   demux1x4_buffered #(.WIDTH(4), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
      .in_sel(inSel), .out_valid(outValid), .out_ready(outReady), .out_data(outData),
      .out_count(outCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int qSize(input int ch);
      return ch == 0 ? q0.size() : ch == 1 ? q1.size() : ch == 2 ? q2.size() : q3.size();
   endfunction

   function automatic logic [3:0] qPop(input int ch);
      return ch == 0 ? q0.pop_front() : ch == 1 ? q1.pop_front() : ch == 2 ? q2.pop_front() : q3.pop_front();
   endfunction

   task automatic qPush(input int ch, input logic [3:0] d);
      if (ch == 0) q0.push_back(d);
      else if (ch == 1) q1.push_back(d);
      else if (ch == 2) q2.push_back(d);
      else q3.push_back(d);
   endtask

   // monitor: inputs settle 1 time unit after posedge, so a handshake seen here fires on the next edge
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid%0d", i), 32'(outValid[i]), 32'(qSize(i) != 0));
            chk($sformatf("count%0d", i), 32'(outCount[i*2 +: 2]), 32'(qSize(i)));
            if (outValid[i] && outReady[i]) begin
               if (qSize(i) == 0) chk($sformatf("extra_pop%0d", i), 32'(qSize(i)), 1);
               else chk($sformatf("data%0d", i), 32'(outData[i*4 +: 4]), 32'(qPop(i)));
            end
         end
      end
   end

   // called and returns at posedge+1
   task automatic push(input logic [1:0] s, input logic [3:0] d, input logic [3:0] rdy, input bit expAcc);
      inValid = 1;
      inSel = s;
      inData = d;
      outReady = rdy;
      #1 chk($sformatf("in_ready_sel%0d", s), 32'(inReady), 32'(expAcc));
      @(posedge clk);
      if (expAcc) qPush(s, d);
      #1 inValid = 0;
   endtask

   task automatic idle(input logic [3:0] rdy, input int n);
      inValid = 0;
      outReady = rdy;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(outValid), 0);
      chk("rst_count", 32'(outCount), 0);
      chk("rst_data", 32'(outData), 0);
      chk("rst_in_ready", 32'(inReady), 1);
      rst = 0;
      idle(4'b0000, 1);
      // routing
      push(0, 4'hA, 4'b0000, 1);
      push(1, 4'h5, 4'b0000, 1);
      push(2, 4'hC, 4'b0000, 1);
      push(3, 4'h3, 4'b0000, 1);
      chk("route_valid", 32'(outValid), 32'hF);
      chk("route_data", 32'(outData), 32'h3C5A);
      chk("route_count", 32'(outCount), 32'h55);
      idle(4'b1111, 1);
      idle(4'b0000, 1);
      // backpressure isolation
      push(1, 4'h1, 4'b0000, 1);
      push(1, 4'h2, 4'b0000, 1);
      inSel = 1;
      #1 chk("bp_ready_sel1", 32'(inReady), 0);
      inSel = 0;
      #1 chk("bp_ready_sel0", 32'(inReady), 1);
      @(posedge clk);
      #1;
      push(0, 4'h7, 4'b0000, 1);
      chk("bp_count", 32'(outCount), 32'h09);
      idle(4'b1111, 2);
      idle(4'b0000, 1);
      // full channel with same-cycle pop
      push(3, 4'h1, 4'b0000, 1);
      push(3, 4'h2, 4'b0000, 1);
      push(3, 4'hE, 4'b1000, 0);
      chk("full_pop_count", 32'(outCount[7:6]), 1);
      push(3, 4'hE, 4'b0000, 1);
      chk("full_retry_count", 32'(outCount[7:6]), 2);
      idle(4'b1111, 2);
      idle(4'b0000, 1);
      // streaming with pointer wrap
      for (int i = 0; i < 10; i++) begin
         if (i > 0) chk("stream_count", 32'(outCount[1:0]), 1);
         push(0, 4'(i), 4'b0001, 1);
      end
      idle(4'b0001, 1);
      // empty pop
      idle(4'b1111, 3);
      chk("empty_valid", 32'(outValid), 0);
      chk("empty_count", 32'(outCount), 0);
      idle(4'b0000, 1);
      // reset mid-run
      push(2, 4'h1, 4'b0000, 1);
      push(2, 4'h2, 4'b0000, 1);
      inSel = 2;
      rst = 1;
      q2.delete();
      #1;
      chk("midrst_valid", 32'(outValid), 0);
      chk("midrst_count", 32'(outCount), 0);
      chk("midrst_data", 32'(outData), 0);
      chk("midrst_in_ready", 32'(inReady), 1);
      @(posedge clk);
      #1 rst = 0;
      @(posedge clk);
      #1;
      push(2, 4'h6, 4'b0000, 1);
      chk("post_rst_data", 32'(outData[11:8]), 32'h6);
      idle(4'b0100, 1);
      idle(4'b0000, 1);
      chk("final_valid", 32'(outValid), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/demux1x4_buffered.md
Name: demux1x4_buffered

Overview:
- 1-to-4 demultiplexer with per-channel buffering. It is the receiving-side counterpart of the 4x1 multibit mux: one shared stream of WIDTH-bit words arrives, each tagged with a 2-bit select, and is routed into one of four independent output channels.
- Each channel owns a small FIFO with a valid/ready handshake, so a stalled consumer blocks only traffic for its own channel.
- Sits downstream of a channel-multiplexed link, ahead of per-channel consumers.

Parameters:
- WIDTH, 4, data bits per word and per channel.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word for channel in_sel this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel, 0..3.
- out_valid  output  4  bit i: channel i has a word at its head.
- out_ready  input  4  bit i: consumer i takes the head word.
- out_data  output  4*WIDTH  channel i head word in bits [i*WIDTH +: WIDTH].
- out_count  output  4*($clog2(DEPTH)+1)  channel i occupancy, packed like out_data.

Behaviour:
- Reset (asynchronous, active-high). While rst=1 or after its release:
  - all read/write pointers and occupancies are 0;
  - out_valid=4'b0000, out_count=0, out_data=0;
  - storage is cleared to 0.
  - Reset mid-transfer discards all buffered words, with no partial output. in_ready goes to 1 as soon as state is clear.
- in_ready = ~full[in_sel]. This is combinational from in_sel and occupancy only, never from in_valid.
- Write: when in_valid & in_ready, in_data is stored at the tail of FIFO[in_sel] and occupancy[in_sel] increments. The other channels are untouched.
- Read: when out_valid[i] & out_ready[i], the head of FIFO[i] is popped and occupancy[i] decrements. All four channels may pop in the same cycle.
- out_valid[i] = (occupancy[i] != 0). out_data for channel i is the storage at read pointer i.
  - When channel i is empty, out_data holds its last head value (0 after reset). Consumers must ignore it.
- Latency: a word accepted at edge N appears with out_valid high after edge N; that is 1 cycle. There is no combinational input-to-output fall-through path.
- Simultaneous write and read on the same channel, not full: occupancy is unchanged, both pointers advance.
- Full channel with a read in the same cycle: in_ready stays 0 (no bypass). The write must retry next cycle.
- Empty channel with out_ready=1: no pop, no pointer change, no error.
- Pointers wrap modulo DEPTH. Occupancy range is 0..DEPTH inclusive.
- If in_valid is deasserted, in_sel and in_data are don't-care and nothing is written.
- Handshake rule for the source: once in_valid is asserted, hold in_valid/in_sel/in_data until accepted.
- Word ordering is preserved per channel. There is no ordering guarantee across channels.

Decomposition:
- Shared package:
  - NUM_CH=4 and SEL_W=2;
  - a function for occupancy width ($clog2(DEPTH)+1);
  - channel-slice index helper constants.
- One sub-module, demux_chan_fifo (WIDTH, DEPTH): single-channel sync FIFO with wr_en, wr_data, rd_en, rd_data, full, empty, count, plus async active-high reset.
- Top instantiates four copies. It decodes in_sel into per-channel wr_en and muxes the full flags into in_ready.

Test Plan:
- Reset: assert rst mid-run with channel 2 holding 2 words → out_valid=0000, out_count all 0, in_ready=1 immediately. The word pushed after release is the only one seen.
- Routing: push 4'hA→sel 0, 4'h5→sel 1, 4'hC→sel 2, 4'h3→sel 3, out_ready=0000 → out_valid=1111, out_data=16'h3C5A, each count=1.
- Backpressure isolation: fill channel 1 (DEPTH=2, words 4'h1, 4'h2) → in_ready=0 when in_sel=1 and 1 when in_sel=0. A push 4'h7 to channel 0 is accepted while channel 1 is stalled.
- Full with same-cycle pop: channel 3 full, out_ready[3]=1 and in_valid to sel 3 in the same cycle → word not accepted that cycle, count goes 2→1. The retry is accepted next cycle and count returns to 2.
- Streaming and wrap: continuous in_valid to channel 0 with out_ready[0]=1, words 0..9 → outputs 0..9 in order, 1-cycle latency, count steady at 1, pointers wrap without loss.
- Empty pop: out_ready=1111 with all empty → no state change, out_valid stays 0000.
